// File: rtl/serial_four_bit_subtractor.sv
// rtl/serial_four_bit_subtractor.sv - bit-serial subtractor, D = A - B - BIN, LSB first
//
// Purpose: computes D = A - B - BIN (modulo 2^WIDTH) one bit per clock
//          through a single borrow flop. The final borrow comes out on BOUT.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, sampled only while idle
//   A, B  - minuend / subtrahend, captured when start is accepted
//   BIN   - borrow-in, captured when start is accepted
//   D     - difference, holds until the next operation completes
//   BOUT  - final borrow-out (1 when A < B + BIN, unsigned)
//   valid - one-cycle pulse when D/BOUT have just been updated
//   busy  - high while an operation is in flight (RUN or DONE)
module serial_four_bit_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             valid_q, valid_d;

  logic bit_a, bit_b, diff_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bout_d   = bout_q;
    valid_d  = 1'b0;
    bit_a    = a_q[0];
    bit_b    = b_q[0];
    diff_bit = bit_a ^ bit_b ^ br_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = BIN;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Borrow out of a full subtractor cell: a < b, or a == b with a borrow pending.
        br_d  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        // Result bits enter at the MSB end so that after WIDTH shifts
        // the first (LSB) result bit has reached bit 0.
        res_d = res_q >> 1;
        res_d[WIDTH-1] = diff_bit;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Outputs are registered on the edge leaving DONE, so valid, D and
        // BOUT all change together in the following cycle.
        valid_d = 1'b1;
        d_d     = res_q;
        bout_d  = br_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign D     = d_q;
  assign BOUT  = bout_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_serial_four_bit_subtractor.sv
// tb/tb_serial_four_bit_subtractor.sv - self-checking bench for serial_four_bit_subtractor
module tb_serial_four_bit_subtractor;

  localparam int W = 4;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BIN;
  logic [W-1:0] D;
  logic         BOUT;
  logic         valid;
  logic         busy;

  int passed;
  int total;

  serial_four_bit_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .D     (D),
    .BOUT  (BOUT),
    .valid (valid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic.
  function automatic logic [W-1:0] model_d(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int diff;
    diff = int'(a) - int'(b) - int'(bin);
    return W'(diff);
  endfunction

  function automatic logic model_bout(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int diff;
    diff = int'(a) - int'(b) - int'(bin);
    return (diff < 0);
  endfunction

  // Drives one operation and measures it; no comparisons here.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] d, output logic bout, output int lat,
                        output logic busy_run, output logic [W-1:0] d_mid);
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    BIN = bin;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    BIN = 1'($urandom);
    busy_run = busy;
    d_mid = D;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) d_mid = D;
    end while (valid !== 1'b1 && lat < 20);
    d = D;
    bout = BOUT;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    BIN = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({D, BOUT, valid, busy} !== {{W{1'b0}}, 3'b000}) $display("FAIL reset_outputs D=%b BOUT=%b valid=%b busy=%b required all zero", D, BOUT, valid, busy);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({valid, busy} !== 2'b00) $display("FAIL reset_release valid=%b busy=%b required 0 0", valid, busy);
    else passed++;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{4'b0011, 4'b1011, 4'b0011, 4'b0000};
    logic [W-1:0] tb [4] = '{4'b0011, 4'b0111, 4'b1011, 4'b0000};
    logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] ed [4] = '{4'b0000, 4'b0011, 4'b1000, 4'b1111};
    logic         eb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] d, d_mid, prev;
    logic bout, busy_run;
    int lat;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tc[i], d, bout, lat, busy_run, d_mid);
      total++;
      if (lat !== LAT) $display("FAIL dir%0d_latency got=%0d required=%0d", i, lat, LAT);
      else passed++;
      total++;
      if (d !== ed[i] || bout !== eb[i]) $display("FAIL dir%0d_result D=%b BOUT=%b required D=%b BOUT=%b", i, d, bout, ed[i], eb[i]);
      else passed++;
      total++;
      if (busy_run !== 1'b1) $display("FAIL dir%0d_busy_run got=%b required=1", i, busy_run);
      else passed++;
      total++;
      if (d_mid !== prev) $display("FAIL dir%0d_hold D=%b required=%b", i, d_mid, prev);
      else passed++;
      @(negedge clk);
      total++;
      if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL dir%0d_pulse valid=%b busy=%b required 0 0", i, valid, busy);
      else passed++;
      prev = ed[i];
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int extra;
    @(negedge clk);
    start = 1'b1; A = 4'b1111; B = 4'b0001; BIN = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    @(negedge clk);
    lat++;
    start = 1'b1; A = 4'b0000; B = 4'b0001; BIN = 1'b0;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== LAT) $display("FAIL busy_ignore_latency got=%0d required=%0d", lat, LAT);
    else passed++;
    total++;
    if (D !== 4'b1110 || BOUT !== 1'b0) $display("FAIL busy_ignore_result D=%b BOUT=%b required D=1110 BOUT=0", D, BOUT);
    else passed++;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) $display("FAIL busy_ignore_extra_valid got=%0d required=0", extra);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] a, b, d, d_mid;
    logic bin, bout, busy_run;
    int lat, extra;
    @(negedge clk);
    start = 1'b1; A = 4'b0101; B = 4'b0011; BIN = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({D, BOUT, valid, busy} !== {{W{1'b0}}, 3'b000}) $display("FAIL abort_async D=%b BOUT=%b valid=%b busy=%b required all zero", D, BOUT, valid, busy);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) $display("FAIL abort_no_valid got=%0d required=0", extra);
    else passed++;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    run_op(a, b, bin, d, bout, lat, busy_run, d_mid);
    total++;
    if (lat !== LAT || d !== model_d(a, b, bin) || bout !== model_bout(a, b, bin))
      $display("FAIL abort_recover lat=%0d D=%b BOUT=%b required lat=%0d D=%b BOUT=%b", lat, d, bout, LAT, model_d(a, b, bin), model_bout(a, b, bin));
    else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, d, d_mid;
    logic bin, bout, busy_run;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      run_op(a, b, bin, d, bout, lat, busy_run, d_mid);
      total++;
      if (lat !== LAT || d !== model_d(a, b, bin) || bout !== model_bout(a, b, bin))
        $display("FAIL rand%0d a=%b b=%b bin=%b lat=%0d D=%b BOUT=%b required lat=%0d D=%b BOUT=%b",
                 i, a, b, bin, lat, d, bout, LAT, model_d(a, b, bin), model_bout(a, b, bin));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic bin;
    int gap, pulses, guard;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    @(negedge clk);
    start = 1'b1; A = a; B = b; BIN = bin;
    pulses = 0; gap = 0; guard = 0;
    while (pulses < 4 && guard < 60) begin
      @(negedge clk);
      guard++;
      gap++;
      if (valid === 1'b1) begin
        total++;
        if (D !== model_d(a, b, bin) || BOUT !== model_bout(a, b, bin))
          $display("FAIL b2b_result%0d D=%b BOUT=%b required D=%b BOUT=%b", pulses, D, BOUT, model_d(a, b, bin), model_bout(a, b, bin));
        else passed++;
        if (pulses > 0) begin
          total++;
          if (gap !== W + 2) $display("FAIL b2b_period%0d got=%0d required=%0d", pulses, gap, W + 2);
          else passed++;
        end
        pulses++;
        gap = 0;
      end
    end
    total++;
    if (pulses !== 4) $display("FAIL b2b_timeout pulses=%0d required=4", pulses);
    else passed++;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
